// File: rtl/timer_scheduler.sv
// timer_scheduler: two-requester one-shot delay service. Each grant programs an
// interval timer slave over a write-only bus (period low/high, control), waits
// for the timer interrupt, clears the timeout flag, then pulses done.
// Build option: TIMER_SCHED_RR_EN selects round-robin arbitration; when it is
// not defined, requester 0 always has priority.
module timer_scheduler #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req_i,
   input  logic [31:0]     req0_delay_i,
   input  logic [31:0]     req1_delay_i,
   output logic [NREQ-1:0] done_o,
   output logic            grant_id_o,
   output logic            busy_o,
   output logic [15:0]     done_count_o,
   output logic [2:0]      tmr_address_o,
   output logic            tmr_chipselect_o,
   output logic            tmr_write_n_o,
   output logic [15:0]     tmr_writedata_o,
   input  logic            tmr_irq_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTRL, S_WAIT_IRQ, S_CLR_STAT, S_DONE
   } state_t;

   localparam logic [2:0]  ADDR_STATUS = 3'd0;
   localparam logic [2:0]  ADDR_CTRL   = 3'd1;
   localparam logic [2:0]  ADDR_PL     = 3'd2;
   localparam logic [2:0]  ADDR_PH     = 3'd3;
   // START | ITO, one-shot (CONT clear)
   localparam logic [15:0] CTRL_START  = 16'h0005;

   state_t      state_q, state_d;
   logic [31:0] delay_q, delay_d;
   logic        grant_q, grant_d;
   logic        busy_q, busy_d;
   logic [15:0] done_count_q, done_count_d;
   logic        win;
   logic [31:0] win_delay;
   logic        grant_now;

`ifdef TIMER_SCHED_RR_EN
   logic ptr_q, ptr_d;

   // Round-robin: the pointed-to requester wins if pending, otherwise the other one
   always_comb begin
      win       = req_i[ptr_q] ? ptr_q : ~ptr_q;
      win_delay = win ? req1_delay_i : req0_delay_i;
   end
`else
   // Fixed priority: requester 0 wins whenever it is pending
   always_comb begin
      win       = req_i[0] ? 1'b0 : 1'b1;
      win_delay = win ? req1_delay_i : req0_delay_i;
   end
`endif

   assign grant_now = (state_q == S_IDLE) && (|req_i);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a zero delay skips the timer entirely
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (|req_i) state_d = (win_delay == 32'd0) ? S_DONE : S_WR_PL;
         S_WR_PL:    state_d = S_WR_PH;
         S_WR_PH:    state_d = S_GAP;
         S_GAP:      state_d = S_WR_CTRL;
         S_WR_CTRL:  state_d = S_WAIT_IRQ;
         S_WAIT_IRQ: if (tmr_irq_i) state_d = S_CLR_STAT;
         S_CLR_STAT: state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Grant bookkeeping: latch winner and delay at grant, count completions at DONE
   always_comb begin
      delay_d      = delay_q;
      grant_d      = grant_q;
      busy_d       = busy_q;
      done_count_d = done_count_q;
`ifdef TIMER_SCHED_RR_EN
      ptr_d        = ptr_q;
`endif
      if (grant_now) begin
         delay_d = win_delay;
         grant_d = win;
         busy_d  = 1'b1;
`ifdef TIMER_SCHED_RR_EN
         ptr_d   = ~win;
`endif
      end else if (state_q == S_DONE) begin
         busy_d       = 1'b0;
         done_count_d = done_count_q + 16'd1;
      end
   end

   // Grant bookkeeping registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         delay_q      <= '0;
         grant_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_count_q <= '0;
`ifdef TIMER_SCHED_RR_EN
         ptr_q        <= 1'b0;
`endif
      end else begin
         delay_q      <= delay_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         done_count_q <= done_count_d;
`ifdef TIMER_SCHED_RR_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   // Outputs: one-cycle timer writes per write state, done pulse in DONE
   always_comb begin
      done_o           = '0;
      tmr_chipselect_o = 1'b0;
      tmr_write_n_o    = 1'b1;
      tmr_address_o    = '0;
      tmr_writedata_o  = '0;
      unique case (state_q)
         S_WR_PL: begin
            tmr_chipselect_o = 1'b1;
            tmr_write_n_o    = 1'b0;
            tmr_address_o    = ADDR_PL;
            tmr_writedata_o  = delay_q[15:0];
         end
         S_WR_PH: begin
            tmr_chipselect_o = 1'b1;
            tmr_write_n_o    = 1'b0;
            tmr_address_o    = ADDR_PH;
            tmr_writedata_o  = delay_q[31:16];
         end
         S_WR_CTRL: begin
            tmr_chipselect_o = 1'b1;
            tmr_write_n_o    = 1'b0;
            tmr_address_o    = ADDR_CTRL;
            tmr_writedata_o  = CTRL_START;
         end
         S_CLR_STAT: begin
            tmr_chipselect_o = 1'b1;
            tmr_write_n_o    = 1'b0;
            tmr_address_o    = ADDR_STATUS;
            tmr_writedata_o  = 16'h0000;
         end
         S_DONE:  done_o[grant_q] = 1'b1;
         default: ;
      endcase
   end

   assign grant_id_o   = grant_q;
   assign busy_o       = busy_q;
   assign done_count_o = done_count_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a timeline-based model.
module tb_timer_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [31:0] d0 = '0, d1 = '0;
   logic        irq = 1'b0;

   logic [1:0]  done_o;
   logic        grant_id_o, busy_o;
   logic [15:0] done_count_o;
   logic [2:0]  tmr_address_o;
   logic        tmr_chipselect_o, tmr_write_n_o;
   logic [15:0] tmr_writedata_o;

   always #5 clk = ~clk;

   timer_scheduler #(.NREQ(2)) dut (
      .clk(clk), .reset_n(reset_n), .req_i(req),
      .req0_delay_i(d0), .req1_delay_i(d1),
      .done_o(done_o), .grant_id_o(grant_id_o), .busy_o(busy_o),
      .done_count_o(done_count_o), .tmr_address_o(tmr_address_o),
      .tmr_chipselect_o(tmr_chipselect_o), .tmr_write_n_o(tmr_write_n_o),
      .tmr_writedata_o(tmr_writedata_o), .tmr_irq_i(irq)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A service is a timeline counted in cycles after the grant edge:
   // +1 period low, +2 period high, +3 quiet, +4 control, then waiting from +5;
   // once irq is seen at cycle w, status clear at w+1 and done at w+2.
   // A zero delay completes in cycle +1 with no bus activity.
   logic        m_busy = 1'b0, m_gid = 1'b0, m_ptr = 1'b0, m_win, m_fin;
   int          m_off = 0, m_irq_off = 0;
   logic [31:0] m_delay = '0;
   logic [15:0] m_cnt = '0, cnt_ofs = '0;

   logic [1:0]  e_done;
   logic        e_cs, e_wn;
   logic [2:0]  e_addr;
   logic [15:0] e_data, e_cnt;

   always_comb begin
      m_win = 1'b0;
`ifdef TIMER_SCHED_RR_EN
      m_win = req[m_ptr] ? m_ptr : ~m_ptr;
`else
      m_win = req[0] ? 1'b0 : 1'b1;
`endif
   end

   always_comb begin
      m_fin = 1'b0;
      if (m_busy)
         m_fin = (m_delay == 0) ? (m_off == 1) : (m_irq_off != 0 && m_off == m_irq_off + 2);
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0; m_gid <= 1'b0; m_ptr <= 1'b0;
         m_off <= 0; m_irq_off <= 0; m_delay <= '0; m_cnt <= '0;
      end else if (!m_busy) begin
         if (req != 2'b00) begin
            m_busy    <= 1'b1;
            m_gid     <= m_win;
            m_delay   <= m_win ? d1 : d0;
            m_off     <= 1;
            m_irq_off <= 0;
            m_ptr     <= ~m_win;
         end
      end else if (m_fin) begin
         m_busy <= 1'b0;
         m_cnt  <= m_cnt + 16'd1;
      end else begin
         if (m_delay != 0 && m_off >= 5 && m_irq_off == 0 && irq) m_irq_off <= m_off;
         m_off <= m_off + 1;
      end
   end

   always_comb begin
      e_done = 2'b00; e_cs = 1'b0; e_addr = 3'd0; e_data = 16'h0;
      if (m_busy) begin
         if (m_fin) e_done[m_gid] = 1'b1;
         else if (m_delay != 0) begin
            if (m_off == 1)      begin e_cs = 1'b1; e_addr = 3'd2; e_data = m_delay[15:0];  end
            else if (m_off == 2) begin e_cs = 1'b1; e_addr = 3'd3; e_data = m_delay[31:16]; end
            else if (m_off == 4) begin e_cs = 1'b1; e_addr = 3'd1; e_data = 16'h0005;       end
            else if (m_irq_off != 0 && m_off == m_irq_off + 1) begin
               e_cs = 1'b1; e_addr = 3'd0; e_data = 16'h0000;
            end
         end
      end
      e_wn  = ~e_cs;
      e_cnt = m_cnt + cnt_ofs;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("done", done_o, e_done);
      chk("busy", busy_o, m_busy);
      chk("grant_id", grant_id_o, m_gid);
      chk("done_count", done_count_o, e_cnt);
      chk("tmr_chipselect", tmr_chipselect_o, e_cs);
      chk("tmr_write_n", tmr_write_n_o, e_wn);
      chk("tmr_address", tmr_address_o, e_addr);
      chk("tmr_writedata", tmr_writedata_o, e_data);
   end

   // Bus write log for the directed scenarios
   int          cyc = 0;
   logic [19:0] log_q[$];
   int          log_cyc[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (tmr_chipselect_o) begin
         log_q.push_back({tmr_write_n_o, tmr_address_o, tmr_writedata_o});
         log_cyc.push_back(cyc);
      end
   end

   task automatic wait_done(input int limit, output logic [1:0] dv, output int n);
      dv = 2'b00; n = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (done_o != 2'b00) begin
            dv = done_o;
            break;
         end
      end
   endtask

   task automatic clear_log();
      log_q.delete();
      log_cyc.delete();
   endtask

   logic [1:0] dv;
   int         n;
   logic       eg;

   initial begin
      // reset state
      reset_n = 1'b0;
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_wn", tmr_write_n_o, 1);
      chk("rst_cs", tmr_chipselect_o, 0);
      chk("rst_cnt", done_count_o, 0);
      chk("rst_grant", grant_id_o, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // requester 0, delay 100, irq arrives late
      clear_log();
      d0 = 32'd100; req = 2'b01; irq = 1'b0;
      repeat (12) @(negedge clk);
      irq = 1'b1;
      wait_done(40, dv, n);
      req = 2'b00; irq = 1'b0;
      chk("t100_done", dv, 2'b01);
      chk("t100_nwr", log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk("t100_pl", log_q[0], {1'b0, 3'd2, 16'h0064});
         chk("t100_ph", log_q[1], {1'b0, 3'd3, 16'h0000});
         chk("t100_ctrl", log_q[2], {1'b0, 3'd1, 16'h0005});
         chk("t100_stat", log_q[3], {1'b0, 3'd0, 16'h0000});
         chk("t100_gap", log_cyc[2] - log_cyc[1], 2);
      end
      @(negedge clk);
      chk("t100_cnt", done_count_o, 1);
      chk("t100_idle", busy_o, 0);

      // requester 1, 32-bit delay, irq already high: minimum latency
      clear_log();
      d1 = 32'h0001_2345; req = 2'b10; irq = 1'b1;
      wait_done(40, dv, n);
      req = 2'b00; irq = 1'b0;
      chk("t12345_done", dv, 2'b10);
      chk("t12345_lat", n, 7);
      chk("t12345_nwr", log_q.size(), 4);
      if (log_q.size() >= 2) begin
         chk("t12345_pl", log_q[0], {1'b0, 3'd2, 16'h2345});
         chk("t12345_ph", log_q[1], {1'b0, 3'd3, 16'h0001});
      end

      // zero delay: done the cycle after the grant, no bus traffic
      @(negedge clk);
      clear_log();
      d0 = 32'd0; req = 2'b01;
      wait_done(10, dv, n);
      req = 2'b00;
      chk("t0_done", dv, 2'b01);
      chk("t0_lat", n, 1);
      @(negedge clk);
      chk("t0_nwr", log_q.size(), 0);
      chk("t0_cnt", done_count_o, 3);

      // both held: arbitration order and no grant in the DONE cycle
      reset_n = 1'b0; cnt_ofs = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      d0 = 32'd0; d1 = 32'd0; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_done(10, dv, n);
`ifdef TIMER_SCHED_RR_EN
         eg = k[0];
`else
         eg = 1'b0;
`endif
         chk("arb_grant", grant_id_o, eg);
         chk("arb_done", dv, eg ? 2'b10 : 2'b01);
         if (k > 0) chk("arb_spacing", n, 2);
      end
      req = 2'b00;
      @(negedge clk);

      // reset while waiting for irq
      clear_log();
      d0 = 32'd5; req = 2'b01; irq = 1'b0;
      n = 0;
      while (n < 20 && log_q.size() < 3) begin
         @(negedge clk);
         n++;
      end
      chk("rstw_ctrl_seen", log_q.size(), 3);
      repeat (3) @(negedge clk);
      reset_n = 1'b0; req = 2'b00; cnt_ofs = '0;
      #1;
      chk("rstw_busy", busy_o, 0);
      chk("rstw_done", done_o, 0);
      chk("rstw_cs", tmr_chipselect_o, 0);
      chk("rstw_wn", tmr_write_n_o, 1);
      chk("rstw_addr", tmr_address_o, 0);
      chk("rstw_data", tmr_writedata_o, 0);
      chk("rstw_cnt", done_count_o, 0);
      chk("rstw_grant", grant_id_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("rstw_nodone", done_o, 0);
      end
      d0 = 32'd7; req = 2'b01; irq = 1'b1;
      wait_done(30, dv, n);
      req = 2'b00; irq = 1'b0;
      chk("rstw_after_done", dv, 2'b01);
      @(negedge clk);
      chk("rstw_after_cnt", done_count_o, 1);

      // randomized traffic, stray irq everywhere
      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (req[i] == 1'b0) begin
               if ($urandom % 5 == 0) begin
                  case ($urandom % 4)
                     0:       d0 = 32'd0;
                     1:       d0 = $urandom % 16;
                     2:       d0 = $urandom;
                     default: d0 = {14'd0, 2'($urandom % 4), 16'($urandom)};
                  endcase
                  if (i == 1) begin d1 = d0; d0 = (req[0] ? d0 : d0 ^ 32'h5A); end
                  req[i] = 1'b1;
               end
            end else if (e_done[i]) begin
               req[i] = 1'b0;
            end else if (m_busy && m_gid == i[0] && $urandom % 50 == 0) begin
               req[i] = 1'b0;
            end
         end
         irq = ($urandom % 3 == 0);
      end
      req = 2'b00; irq = 1'b1;
      repeat (40) @(negedge clk);
      irq = 1'b0;

      // completion counter wraps
      @(negedge clk);
      #1;
      force dut.done_count_q = 16'hFFFF;
      cnt_ofs = 16'hFFFF - m_cnt;
      #1;
      release dut.done_count_q;
      @(negedge clk);
      chk("wrap_preset", done_count_o, 16'hFFFF);
      d0 = 32'd0; req = 2'b01;
      wait_done(10, dv, n);
      req = 2'b00;
      chk("wrap_done", dv, 2'b01);
      @(negedge clk);
      chk("wrap_cnt", done_count_o, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
